// File: rtl/rv_instr_encoder_if.sv
// Request channel and imem write port of the instruction encoder.
// Handshake: a request transfers on every rising edge where req_valid and req_ready are both high.
// The requester holds all req_* fields stable while req_valid is high and req_ready is low.
interface rv_instr_encoder_if #(parameter int ADDR_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [2:0]        req_funct3;
  logic              req_f7b5;
  logic [20:0]       req_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_f7b5, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_f7b5, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Encodes field-level instruction requests into RV32I words and writes them to imem,
// one per cycle, with a sticky first-error code for rejected requests.
module rv_instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  rv_instr_encoder_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] nextAddr;
  logic              accept;
  logic [31:0]       encWord;
  logic [1:0]        encCode;
  logic [20:0]       imm;
  logic              isShift;
  logic              fits12;
  logic              fits13;
  logic              fitsShamt;

  assign imm       = bus.req_imm;
  assign isShift   = (bus.req_funct3 == 3'b001) || (bus.req_funct3 == 3'b101);
  assign fits12    = (imm[20:11] == {10{imm[11]}});
  assign fits13    = (imm[20:12] == {9{imm[12]}});
  assign fitsShamt = (imm[20:5] == 16'd0);

  // The final write is still in flight while count already equals MAX_COUNT,
  // so ready drops in that cycle too, before the state reaches DONE.
  assign bus.req_ready = (state == RUN) & ~full & ~start & (count != MAX_COUNT);
  assign accept        = bus.req_valid & bus.req_ready;
  assign busy          = (state == RUN);
  assign full          = (state == DONE);
  assign dbgState      = state;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (!start && count == MAX_COUNT) stateNext = DONE;
      DONE:    if (start) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  // encCode: 0 legal, 1 bad kind, 2 immediate out of range, 3 misaligned (checked first)
  always_comb begin
    encWord = 32'd0;
    encCode = 2'd0;
    case (bus.req_kind)
      3'd0: begin
        encWord = {imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, 7'b0000011};
        if (!fits12) encCode = 2'd2;
      end
      3'd1: begin
        encWord = {imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010, imm[4:0], 7'b0100011};
        if (!fits12) encCode = 2'd2;
      end
      3'd2: begin
        encWord = {1'b0, bus.req_f7b5, 5'b0, bus.req_rs2, bus.req_rs1, bus.req_funct3,
                   bus.req_rd, 7'b0110011};
      end
      3'd3: begin
        encWord = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, 3'b000, imm[4:1], imm[11],
                   7'b1100011};
        if (imm[0])       encCode = 2'd3;
        else if (!fits13) encCode = 2'd2;
      end
      3'd4: begin
        if (isShift) begin
          encWord = {1'b0, bus.req_f7b5, 5'b0, imm[4:0], bus.req_rs1, bus.req_funct3,
                     bus.req_rd, 7'b0010011};
          if (!fitsShamt) encCode = 2'd2;
        end else begin
          encWord = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, 7'b0010011};
          if (!fits12) encCode = 2'd2;
        end
      end
      3'd5: begin
        // Any even 21-bit value is in range, so only alignment can fail.
        encWord = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, 7'b1101111};
        if (imm[0]) encCode = 2'd3;
      end
      default: encCode = 2'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      nextAddr       <= '0;
      count          <= '0;
      err            <= 1'b0;
      err_code       <= 2'd0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
    end else begin
      state       <= stateNext;
      bus.imem_we <= 1'b0;
      if (start) begin
        nextAddr <= base_addr;
        count    <= '0;
        err      <= 1'b0;
        err_code <= 2'd0;
      end else if (accept) begin
        if (encCode == 2'd0) begin
          bus.imem_we    <= 1'b1;
          bus.imem_addr  <= nextAddr;
          bus.imem_wdata <= encWord;
          nextAddr       <= nextAddr + 1'b1;
          count          <= count + 1'b1;
        end else begin
          err <= 1'b1;
          if (!err) err_code <= encCode;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: a wide instance (ADDR_W=8) and a tiny one (ADDR_W=2) for the full path.
module tb_rv_instr_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUTs ----------------
  rv_instr_encoder_if #(.ADDR_W(8)) busA ();
  rv_instr_encoder_if #(.ADDR_W(2)) busB ();

  logic       startA = 1'b0;
  logic [7:0] baseA = 8'd0;
  logic [8:0] countA;
  logic       busyA, fullA, errA;
  logic [1:0] codeA, stA;

  logic       startB = 1'b0;
  logic [1:0] baseB = 2'd0;
  logic [2:0] countB;
  logic       busyB, fullB, errB;
  logic [1:0] codeB, stB;

  rv_instr_encoder #(.ADDR_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .base_addr(baseA), .bus(busA),
    .count(countA), .busy(busyA), .full(fullA), .err(errA), .err_code(codeA), .dbgState(stA)
  );

  rv_instr_encoder #(.ADDR_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .base_addr(baseB), .bus(busB),
    .count(countB), .busy(busyB), .full(fullB), .err(errB), .err_code(codeB), .dbgState(stB)
  );

  // ---------------- reference model state ----------------
  int expAddrA = 0, expCountA = 0, expErrA = 0, expCodeA = 0;
  int expAddrB = 0, expCountB = 0;

  // {cycle of write, address, word}
  logic [71:0] expA_q[$];
  logic [71:0] expB_q[$];

  // Builds the instruction word from the ISA field layout with plain arithmetic.
  function automatic void model_encode(input int kind, input int rd, input int rs1, input int rs2,
                                       input int f3, input int f7b5, input int imm,
                                       output int code, output logic [31:0] word);
    int acc;
    code = 0;
    acc  = 0;
    case (kind)
      0: begin
        if (imm < -2048 || imm > 2047) code = 2;
        acc = ((imm & 'hFFF) << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 'h03;
      end
      1: begin
        if (imm < -2048 || imm > 2047) code = 2;
        acc = (((imm >> 5) & 'h7F) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12)
            + ((imm & 'h1F) << 7) + 'h23;
      end
      2: acc = (f7b5 << 30) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
      3: begin
        if (imm % 2 != 0) code = 3;
        else if (imm < -4096 || imm > 4094) code = 2;
        acc = (((imm >> 12) & 1) << 31) + (((imm >> 5) & 'h3F) << 25) + (rs2 << 20)
            + (rs1 << 15) + (((imm >> 1) & 'hF) << 8) + (((imm >> 11) & 1) << 7) + 'h63;
      end
      4: begin
        if (f3 == 1 || f3 == 5) begin
          if (imm < 0 || imm > 31) code = 2;
          acc = (f7b5 << 30) + ((imm & 'h1F) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
        end else begin
          if (imm < -2048 || imm > 2047) code = 2;
          acc = ((imm & 'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
        end
      end
      5: begin
        if (imm % 2 != 0) code = 3;
        acc = (((imm >> 20) & 1) << 31) + (((imm >> 1) & 'h3FF) << 21) + (((imm >> 11) & 1) << 20)
            + (((imm >> 12) & 'hFF) << 12) + (rd << 7) + 'h6F;
      end
      default: code = 1;
    endcase
    word = 32'(acc);
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (busA.imem_we === 1'b1) begin
      logic [71:0] got;
      logic [71:0] e;
      got = {32'(cyc), busA.imem_addr, busA.imem_wdata};
      n_tests++;
      if (expA_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_a_unexpected: got cyc=%0d addr=%h wdata=%h, required no write",
                 cyc, busA.imem_addr, busA.imem_wdata);
      end else begin
        e = expA_q.pop_front();
        if (got !== e)
          begin
            n_fail++;
            $display("FAIL wr_a: got cyc=%0d addr=%h wdata=%h, required cyc=%0d addr=%h wdata=%h",
                     got[71:40], got[39:32], got[31:0], e[71:40], e[39:32], e[31:0]);
          end
      end
    end
  end

  always @(negedge clk) begin
    if (busB.imem_we === 1'b1) begin
      logic [71:0] got;
      logic [71:0] e;
      got = {32'(cyc), 6'd0, busB.imem_addr, busB.imem_wdata};
      n_tests++;
      if (expB_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_b_unexpected: got cyc=%0d addr=%h wdata=%h, required no write",
                 cyc, busB.imem_addr, busB.imem_wdata);
      end else begin
        e = expB_q.pop_front();
        if (got !== e)
          begin
            n_fail++;
            $display("FAIL wr_b: got cyc=%0d addr=%h wdata=%h, required cyc=%0d addr=%h wdata=%h",
                     got[71:40], got[39:32], got[31:0], e[71:40], e[39:32], e[31:0]);
          end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input bit useB, input int base);
    if (useB) begin
      startB = 1'b1; baseB = 2'(base);
      expAddrB = base & 3; expCountB = 0;
    end else begin
      startA = 1'b1; baseA = 8'(base);
      expAddrA = base & 255; expCountA = 0; expErrA = 0; expCodeA = 0;
    end
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic set_fields(input bit useB, input int kind, input int rd, input int rs1,
                            input int rs2, input int f3, input int f7b5, input int imm);
    if (useB) begin
      busB.req_kind = 3'(kind); busB.req_rd = 5'(rd); busB.req_rs1 = 5'(rs1);
      busB.req_rs2 = 5'(rs2); busB.req_funct3 = 3'(f3); busB.req_f7b5 = 1'(f7b5);
      busB.req_imm = 21'(imm); busB.req_valid = 1'b1;
    end else begin
      busA.req_kind = 3'(kind); busA.req_rd = 5'(rd); busA.req_rs1 = 5'(rs1);
      busA.req_rs2 = 5'(rs2); busA.req_funct3 = 3'(f3); busA.req_f7b5 = 1'(f7b5);
      busA.req_imm = 21'(imm); busA.req_valid = 1'b1;
    end
  endtask

  // Presents one request, waits for the handshake edge and records the expected outcome.
  task automatic send(input bit useB, input int kind, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7b5, input int imm);
    int code;
    logic [31:0] w;
    int budget;
    set_fields(useB, kind, rd, rs1, rs2, f3, f7b5, imm);
    budget = 0;
    forever begin
      @(negedge clk);
      if ((useB ? busB.req_ready : busA.req_ready) === 1'b1) break;
      budget++;
      if (budget > 20) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: got req_ready=0 for %0d cycles, required 1", budget);
        busA.req_valid = 1'b0; busB.req_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    model_encode(kind, rd, rs1, rs2, f3, f7b5, imm, code, w);
    if (useB) begin
      if (code == 0) begin
        expB_q.push_back({32'(cyc + 1), 8'(expAddrB), w});
        expAddrB = (expAddrB + 1) & 3; expCountB++;
      end
    end else begin
      if (code == 0) begin
        expA_q.push_back({32'(cyc + 1), 8'(expAddrA), w});
        expAddrA = (expAddrA + 1) & 255; expCountA++;
      end else if (expErrA == 0) begin
        expErrA = 1; expCodeA = code;
      end
    end
    @(posedge clk); #1;
    busA.req_valid = 1'b0;
    busB.req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({busA.req_ready, busA.imem_we, busyA, fullA, errA} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags_a: got %b, required 00000",
                         {busA.req_ready, busA.imem_we, busyA, fullA, errA});
    end
    n_tests++;
    if ({busA.imem_addr, busA.imem_wdata} !== 40'd0) begin
      n_fail++; $display("FAIL reset_addr_wdata_a: got %h/%h, required 0/0",
                         busA.imem_addr, busA.imem_wdata);
    end
    n_tests++;
    if ({countA, codeA, stA} !== 13'd0) begin
      n_fail++; $display("FAIL reset_count_code_a: got count=%0d code=%0d state=%0d, required 0/0/0",
                         countA, codeA, stA);
    end
    n_tests++;
    if ({busB.req_ready, busB.imem_we, busyB, fullB, errB, countB, codeB, stB} !== 12'd0) begin
      n_fail++; $display("FAIL reset_b: got %b, required all zero",
                         {busB.req_ready, busB.imem_we, busyB, fullB, errB, countB, codeB, stB});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busyA !== 1'b0 || busA.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b ready=%b, required 0/0",
                         busyA, busA.req_ready);
    end
  endtask

  task automatic test_lw();
    do_start(0, 'h10);
    send(0, 0, 5, 2, 0, 0, 0, -4);
    @(negedge clk);
    n_tests++;
    if ({busA.imem_we, busA.imem_addr, busA.imem_wdata} !== {1'b1, 8'h10, 32'hFFC12283}) begin
      n_fail++; $display("FAIL lw_write: got we=%b addr=%h wdata=%h, required 1/10/ffc12283",
                         busA.imem_we, busA.imem_addr, busA.imem_wdata);
    end
    @(negedge clk);
    n_tests++;
    if ({busA.imem_we, busA.imem_addr, busA.imem_wdata} !== {1'b0, 8'h10, 32'hFFC12283}) begin
      n_fail++; $display("FAIL lw_hold: got we=%b addr=%h wdata=%h, required 0/10/ffc12283",
                         busA.imem_we, busA.imem_addr, busA.imem_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_start(0, 'h10);
    send(0, 1, 0, 2, 5, 0, 0, 8);
    send(0, 2, 3, 1, 2, 0, 1, 0);
    @(negedge clk);
    n_tests++;
    if ({busA.imem_addr, busA.imem_wdata, countA} !== {8'h11, 32'h402081B3, 9'd2}) begin
      n_fail++; $display("FAIL b2b_rtype: got addr=%h wdata=%h count=%0d, required 11/402081b3/2",
                         busA.imem_addr, busA.imem_wdata, countA);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    do_start(0, 'h20);
    send(0, 3, 0, 1, 2, 0, 0, 3);
    @(negedge clk);
    n_tests++;
    if ({busA.imem_we, errA, codeA, countA} !== {1'b0, 1'b1, 2'd3, 9'd0}) begin
      n_fail++; $display("FAIL beq_misaligned: got we=%b err=%b code=%0d count=%0d, required 0/1/3/0",
                         busA.imem_we, errA, codeA, countA);
    end
    @(posedge clk); #1;
    send(0, 5, 1, 0, 0, 0, 0, 2048);
    @(negedge clk);
    n_tests++;
    if ({busA.imem_we, busA.imem_wdata, codeA, countA} !== {1'b1, 32'h001000EF, 2'd3, 9'd1}) begin
      n_fail++; $display("FAIL jal_after_err: got we=%b wdata=%h code=%0d count=%0d, required 1/001000ef/3/1",
                         busA.imem_we, busA.imem_wdata, codeA, countA);
    end
    @(posedge clk); #1;
    send(0, 7, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if ({errA, codeA} !== {1'b1, 2'd3}) begin
      n_fail++; $display("FAIL err_sticky: got err=%b code=%0d, required 1/3", errA, codeA);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_itype_shift();
    do_start(0, 'h30);
    @(negedge clk);
    n_tests++;
    if ({errA, codeA} !== 3'd0) begin
      n_fail++; $display("FAIL start_clears_err: got err=%b code=%0d, required 0/0", errA, codeA);
    end
    @(posedge clk); #1;
    send(0, 4, 1, 1, 0, 5, 1, 3);
    @(negedge clk);
    n_tests++;
    if ({busA.imem_we, busA.imem_wdata} !== {1'b1, 32'h4030D093}) begin
      n_fail++; $display("FAIL srai: got we=%b wdata=%h, required 1/4030d093",
                         busA.imem_we, busA.imem_wdata);
    end
    @(posedge clk); #1;
    send(0, 4, 1, 1, 0, 5, 1, 32);
    @(negedge clk);
    n_tests++;
    if ({busA.imem_we, errA, codeA} !== {1'b0, 1'b1, 2'd2}) begin
      n_fail++; $display("FAIL shamt_range: got we=%b err=%b code=%0d, required 0/1/2",
                         busA.imem_we, errA, codeA);
    end
    @(posedge clk); #1;
    do_start(0, 'h30);
    send(0, 6, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if ({errA, codeA} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL bad_kind: got err=%b code=%0d, required 1/1", errA, codeA);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    do_start(0, $urandom_range(0, 255));
    for (int i = 0; i < 150; i++) begin
      int imm;
      case ($urandom_range(0, 3))
        0:       imm = int'($urandom_range(0, 80)) - 40;
        1:       imm = int'($urandom_range(0, 10000)) - 5000;
        2:       imm = int'($urandom_range(0, 2097151)) - 1048576;
        default: imm = int'($urandom_range(0, 40));
      endcase
      send(0, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1), imm);
    end
    @(negedge clk);
    n_tests++;
    if ({countA, errA, codeA} !== {9'(expCountA), 1'(expErrA), 2'(expCodeA)}) begin
      n_fail++; $display("FAIL random_totals: got count=%0d err=%b code=%0d, required %0d/%0d/%0d",
                         countA, errA, codeA, expCountA, expErrA, expCodeA);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    int readySeen;
    do_start(1, 3);
    for (int i = 0; i < 4; i++)
      send(1, 0, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0,
           int'($urandom_range(0, 200)) - 100);
    set_fields(1, 0, 1, 1, 0, 0, 0, 4);
    readySeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busB.req_ready !== 1'b0) readySeen++;
    end
    n_tests++;
    if (readySeen != 0) begin
      n_fail++; $display("FAIL full_stall: got req_ready high in %0d cycles, required 0", readySeen);
    end
    n_tests++;
    if ({fullB, busyB, countB} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++; $display("FAIL full_flags: got full=%b busy=%b count=%0d, required 1/0/4",
                         fullB, busyB, countB);
    end
    @(posedge clk); #1;
    busB.req_valid = 1'b0;
    do_start(1, 0);
    @(negedge clk);
    n_tests++;
    if ({fullB, busyB, countB, busB.req_ready} !== {1'b0, 1'b1, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL full_restart: got full=%b busy=%b count=%0d ready=%b, required 0/1/0/1",
                         fullB, busyB, countB, busB.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int weSeen;
    do_start(0, 'h40);
    set_fields(0, 0, 3, 3, 0, 0, 0, 12);
    @(negedge clk);
    n_tests++;
    if (busA.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_ready: got %b, required 1", busA.req_ready);
    end
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    busA.req_valid = 1'b0;
    weSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busA.imem_we !== 1'b0) weSeen++;
    end
    n_tests++;
    if (weSeen != 0 || {busyA, countA} !== 10'd0) begin
      n_fail++; $display("FAIL reset_mid: got we pulses=%0d busy=%b count=%0d, required 0/0/0",
                         weSeen, busyA, countA);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    expAddrA = 0; expCountA = 0; expErrA = 0; expCodeA = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_start_collision();
    do_start(0, 'h50);
    startA = 1'b1;
    set_fields(0, 0, 7, 7, 0, 0, 0, 100);
    @(negedge clk);
    n_tests++;
    if (busA.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL start_collision_ready: got %b, required 0", busA.req_ready);
    end
    @(posedge clk); #1;
    startA = 1'b0;
    busA.req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busA.imem_we, busyA, countA} !== {1'b0, 1'b1, 9'd0}) begin
      n_fail++; $display("FAIL start_collision: got we=%b busy=%b count=%0d, required 0/1/0",
                         busA.imem_we, busyA, countA);
    end
    @(posedge clk); #1;
    send(0, 2, 4, 5, 6, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_fields(0, 0, 0, 0, 0, 0, 0, 0);
    set_fields(1, 0, 0, 0, 0, 0, 0, 0);
    busA.req_valid = 1'b0;
    busB.req_valid = 1'b0;
    test_reset();
    test_lw();
    test_back_to_back();
    test_errors();
    test_itype_shift();
    test_random();
    test_full();
    test_reset_mid();
    test_start_collision();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (expA_q.size() != 0 || expB_q.size() != 0) begin
      n_fail++; $display("FAIL missing_writes: got %0d/%0d outstanding, required 0/0",
                         expA_q.size(), expB_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
